// File: rtl/mem_port_arbiter.sv
// Shares one byte-addressable memory port between instruction fetch and the
// load/store unit: grant -> ACCESS (memory driven) -> RESP (registered response).
module mem_port_arbiter #(
  parameter int AWIDTH       = 32,
  parameter int DWIDTH       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [AWIDTH-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DWIDTH-1:0] if_rdata_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [AWIDTH-1:0] dm_addr_i,
  input  logic [DWIDTH-1:0] dm_wdata_i,
  input  logic [2:0]        dm_funct3_i,
  output logic              dm_gnt_o,
  output logic              dm_rvalid_o,
  output logic [DWIDTH-1:0] dm_rdata_o,
  output logic [AWIDTH-1:0] mem_addr_o,
  output logic [DWIDTH-1:0] mem_data_o,
  output logic              mem_read_en_o,
  output logic              mem_write_en_o,
  output logic [2:0]        mem_funct3_o,
  input  logic [DWIDTH-1:0] mem_data_i,
  output logic              busy_o
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  localparam logic [2:0] FUNCT3_LW  = 3'b010;

  logic [3:0]        starve_cnt;
  logic              fetch_pri;
  logic              if_gnt;
  logic              dm_gnt;

  logic              acc_valid;
  logic              acc_owner_dm;
  logic              acc_we;
  logic [AWIDTH-1:0] acc_addr;
  logic [DWIDTH-1:0] acc_wdata;
  logic [2:0]        acc_funct3;

  logic              if_rvalid_q;
  logic              dm_rvalid_q;
  logic [DWIDTH-1:0] if_rdata_q;
  logic [DWIDTH-1:0] dm_rdata_q;

  // Data wins ties unless fetch has lost STARVE_LIMIT arbitrations in a row;
  // grants are gated by rst so nothing is accepted while reset is asserted.
  assign fetch_pri = (starve_cnt == STARVE_MAX);
  assign if_gnt    = rst & if_req_i & (~dm_req_i | fetch_pri);
  assign dm_gnt    = rst & dm_req_i & ~(if_req_i & fetch_pri);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (if_req_i && !if_gnt) begin
      if (starve_cnt != STARVE_MAX) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end else begin
      starve_cnt <= '0;
    end
  end

  // ACCESS stage: address/data/size hold their last values while idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_valid    <= 1'b0;
      acc_owner_dm <= 1'b0;
      acc_we       <= 1'b0;
      acc_addr     <= '0;
      acc_wdata    <= '0;
      acc_funct3   <= '0;
    end else begin
      acc_valid <= if_gnt | dm_gnt;
      if (dm_gnt) begin
        acc_owner_dm <= 1'b1;
        acc_we       <= dm_we_i;
        acc_addr     <= dm_addr_i;
        acc_wdata    <= dm_wdata_i;
        acc_funct3   <= dm_funct3_i;
      end else if (if_gnt) begin
        acc_owner_dm <= 1'b0;
        acc_we       <= 1'b0;
        acc_addr     <= if_addr_i;
        acc_wdata    <= '0;
        acc_funct3   <= FUNCT3_LW;
      end
    end
  end

  // RESP stage: only the owner's rdata register is updated; stores return 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      if_rvalid_q <= acc_valid & ~acc_owner_dm;
      dm_rvalid_q <= acc_valid & acc_owner_dm;
      if (acc_valid) begin
        if (acc_owner_dm) begin
          dm_rdata_q <= acc_we ? '0 : mem_data_i;
        end else begin
          if_rdata_q <= mem_data_i;
        end
      end
    end
  end

  assign if_gnt_o       = if_gnt;
  assign dm_gnt_o       = dm_gnt;
  assign if_rvalid_o    = if_rvalid_q;
  assign dm_rvalid_o    = dm_rvalid_q;
  assign if_rdata_o     = if_rdata_q;
  assign dm_rdata_o     = dm_rdata_q;
  assign mem_addr_o     = acc_addr;
  assign mem_data_o     = acc_wdata;
  assign mem_funct3_o   = acc_funct3;
  assign mem_read_en_o  = acc_valid & ~acc_we;
  assign mem_write_en_o = acc_valid & acc_we;
  assign busy_o         = acc_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: grant table, randomized traffic
// against a transaction-level model, and hand-written multi-cycle sequences.
module tb_mem_port_arbiter;

  localparam int STARVE_LIMIT = 4;
  localparam int MEM_BYTES    = 4096;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_gnt_o;
  logic        if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        dm_req_i;
  logic        dm_we_i;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_wdata_i;
  logic [2:0]  dm_funct3_i;
  logic        dm_gnt_o;
  logic        dm_rvalid_o;
  logic [31:0] dm_rdata_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic        mem_read_en_o;
  logic        mem_write_en_o;
  logic [2:0]  mem_funct3_o;
  logic [31:0] mem_data_i;
  logic        busy_o;

  int check_cnt = 0;
  int pass_cnt  = 0;

  mem_port_arbiter #(
    .AWIDTH(32), .DWIDTH(32), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i),
    .dm_wdata_i(dm_wdata_i), .dm_funct3_i(dm_funct3_i), .dm_gnt_o(dm_gnt_o),
    .dm_rvalid_o(dm_rvalid_o), .dm_rdata_o(dm_rdata_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_read_en_o(mem_read_en_o), .mem_write_en_o(mem_write_en_o),
    .mem_funct3_o(mem_funct3_o), .mem_data_i(mem_data_i), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  // Byte memory: unwritten bytes read a fixed pattern; stores to address 0 are dropped.
  logic [7:0] dev_mem [0:MEM_BYTES-1];
  bit         dev_written [0:MEM_BYTES-1];
  logic [7:0] ref_mem [0:MEM_BYTES-1];
  bit         ref_written [0:MEM_BYTES-1];
  logic [31:0] dev_raw;

  function automatic logic [7:0] init_byte(input logic [11:0] i);
    logic [11:0] t;
    t = i * 12'd37 + 12'h15A;
    return t[7:0] ^ {i[11:8], i[3:0]};
  endfunction

  function automatic logic [7:0] pick(input bit w, input logic [7:0] d, input logic [11:0] i);
    return w ? d : init_byte(i);
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] raw, input logic [2:0] f3);
    case (f3)
      3'b000:  return {{24{raw[7]}}, raw[7:0]};
      3'b001:  return {{16{raw[15]}}, raw[15:0]};
      3'b100:  return {24'h0, raw[7:0]};
      3'b101:  return {16'h0, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  function automatic int nbytes(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  for (genvar k = 0; k < 4; k++) begin : g_rd
    assign dev_raw[8*k +: 8] = pick(dev_written[12'(mem_addr_o[11:0] + k)],
                                    dev_mem[12'(mem_addr_o[11:0] + k)],
                                    12'(mem_addr_o[11:0] + k));
  end
  assign mem_data_i = extend(dev_raw, mem_funct3_o);

  always @(posedge clk) begin
    if (mem_write_en_o && mem_addr_o != 32'h0) begin
      for (int k = 0; k < 4; k++) begin
        if (k < nbytes(mem_funct3_o)) begin
          dev_mem[12'(mem_addr_o[11:0] + k)]     <= mem_data_o[8*k +: 8];
          dev_written[12'(mem_addr_o[11:0] + k)] <= 1'b1;
        end
      end
    end
  end

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] f3);
    logic [31:0] raw;
    for (int k = 0; k < 4; k++) begin
      raw[8*k +: 8] = pick(ref_written[12'(a[11:0] + k)], ref_mem[12'(a[11:0] + k)],
                           12'(a[11:0] + k));
    end
    return extend(raw, f3);
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
    if (a != 32'h0) begin
      for (int k = 0; k < nbytes(f3); k++) begin
        ref_mem[12'(a[11:0] + k)]     = d[8*k +: 8];
        ref_written[12'(a[11:0] + k)] = 1'b1;
      end
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    check_cnt++;
    if (actual === expected) pass_cnt++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
  endtask

  task automatic applyStimulus(input logic ifr, input logic [31:0] ifa, input logic dmr,
                               input logic we, input logic [31:0] da, input logic [31:0] wd,
                               input logic [2:0] f3);
    if_req_i    = ifr;
    if_addr_i   = ifa;
    dm_req_i    = dmr;
    dm_we_i     = we;
    dm_addr_i   = da;
    dm_wdata_i  = wd;
    dm_funct3_i = f3;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, "_gnt"}, {30'h0, if_gnt_o, dm_gnt_o}, 32'h0);
    checkOutput({tag, "_rvalid"}, {30'h0, if_rvalid_o, dm_rvalid_o}, 32'h0);
    checkOutput({tag, "_rdata"}, if_rdata_o | dm_rdata_o, 32'h0);
    checkOutput({tag, "_mem_addr"}, mem_addr_o, 32'h0);
    checkOutput({tag, "_mem_data"}, mem_data_o, 32'h0);
    checkOutput({tag, "_mem_ctrl"}, {26'h0, mem_read_en_o, mem_write_en_o, mem_funct3_o, busy_o}, 32'h0);
  endtask

  // Requests are held high during reset to show grants are forced low.
  task automatic do_reset();
    rst = 1'b0;
    applyStimulus(1'b1, 32'h0100_0004, 1'b1, 1'b1, 32'h0100_0008, 32'hFFFF_FFFF, 3'b010);
    #2;
    check_all_zero("reset");
    step();
    idle();
    rst = 1'b1;
  endtask

  typedef struct {
    logic if_req;
    logic dm_req;
    logic exp_if_gnt;
    logic exp_dm_gnt;
  } vec_t;

  typedef struct {
    logic        dm;
    logic [31:0] data;
    int          due;
  } resp_t;

  vec_t  vecs [18];
  resp_t exp_q [$];

  task automatic run_table();
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b1};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 1'b1};
    vecs[14] = '{1'b1, 1'b1, 1'b0, 1'b1};
    vecs[15] = '{1'b1, 1'b1, 1'b0, 1'b1};
    vecs[16] = '{1'b1, 1'b1, 1'b0, 1'b1};
    vecs[17] = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i].if_req, 32'h0100_0000, vecs[i].dm_req, 1'b0,
                    32'h0100_0040, 32'h0, 3'b010);
      #1;
      checkOutput($sformatf("tbl%0d_if_gnt", i), {31'h0, if_gnt_o}, {31'h0, vecs[i].exp_if_gnt});
      checkOutput($sformatf("tbl%0d_dm_gnt", i), {31'h0, dm_gnt_o}, {31'h0, vecs[i].exp_dm_gnt});
      step();
    end
    idle();
  endtask

  // Transaction-level model: responses are computed at grant time in grant order.
  task automatic run_random();
    logic [2:0]  st_codes [3];
    logic [2:0]  ld_codes [5];
    int          losses;
    logic        pv, pwe, e_if, e_dm, if_p, dm_p, dm_w, exp_if_rv, exp_dm_rv;
    logic [31:0] paddr, if_a, dm_a, dm_d, last_if, last_dm, d;
    logic [2:0]  dm_f;
    resp_t       r;
    st_codes = '{3'b000, 3'b001, 3'b010};
    ld_codes = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    losses = 0; pv = 0; pwe = 0; paddr = 0; if_p = 0; dm_p = 0; dm_w = 0;
    if_a = 0; dm_a = 0; dm_d = 0; dm_f = 0; last_if = 0; last_dm = 0;
    exp_q.delete();
    for (int cyc = 0; cyc < 600; cyc++) begin
      exp_if_rv = (exp_q.size() > 0) && (exp_q[0].due == cyc) && !exp_q[0].dm;
      exp_dm_rv = (exp_q.size() > 0) && (exp_q[0].due == cyc) && exp_q[0].dm;
      if (exp_if_rv || exp_dm_rv) begin
        r = exp_q.pop_front();
        if (r.dm) last_dm = r.data;
        else last_if = r.data;
      end
      checkOutput("rnd_if_rvalid", {31'h0, if_rvalid_o}, {31'h0, exp_if_rv});
      checkOutput("rnd_dm_rvalid", {31'h0, dm_rvalid_o}, {31'h0, exp_dm_rv});
      checkOutput("rnd_if_rdata", if_rdata_o, last_if);
      checkOutput("rnd_dm_rdata", dm_rdata_o, last_dm);
      checkOutput("rnd_busy", {31'h0, busy_o}, {31'h0, pv});
      checkOutput("rnd_rd_en", {31'h0, mem_read_en_o}, {31'h0, pv & ~pwe});
      checkOutput("rnd_wr_en", {31'h0, mem_write_en_o}, {31'h0, pv & pwe});
      if (pv) checkOutput("rnd_mem_addr", mem_addr_o, paddr);

      if (cyc < 580) begin
        if (!if_p && $urandom_range(0, 9) < 6) begin
          if_p = 1'b1;
          if_a = 32'h0100_0800 + 32'($urandom_range(0, 15) * 4);
        end
        if (!dm_p && $urandom_range(0, 9) < 6) begin
          dm_p = 1'b1;
          dm_w = 1'($urandom_range(0, 1));
          dm_a = (dm_w && $urandom_range(0, 15) == 0) ? 32'h0 : 32'h0100_0800 + 32'($urandom_range(0, 63));
          dm_d = $urandom;
          dm_f = dm_w ? st_codes[$urandom_range(0, 2)] : ld_codes[$urandom_range(0, 4)];
        end
      end
      applyStimulus(if_p, if_a, dm_p, dm_w, dm_a, dm_d, dm_f);
      #1;
      e_dm = dm_p && !(if_p && losses >= STARVE_LIMIT);
      e_if = if_p && !e_dm;
      checkOutput("rnd_if_gnt", {31'h0, if_gnt_o}, {31'h0, e_if});
      checkOutput("rnd_dm_gnt", {31'h0, dm_gnt_o}, {31'h0, e_dm});
      if (if_p && !e_if) losses++;
      else losses = 0;
      pv = e_dm | e_if;
      if (e_dm) begin
        paddr = dm_a;
        pwe   = dm_w;
        if (dm_w) begin
          ref_store(dm_a, dm_d, dm_f);
          d = 32'h0;
        end else begin
          d = ref_load(dm_a, dm_f);
        end
        exp_q.push_back('{1'b1, d, cyc + 2});
        dm_p = 1'b0;
      end else if (e_if) begin
        paddr = if_a;
        pwe   = 1'b0;
        exp_q.push_back('{1'b0, ref_load(if_a, 3'b010), cyc + 2});
        if_p = 1'b0;
      end
      step();
    end
    checkOutput("rnd_queue_drained", exp_q.size(), 32'h0);
    idle();
  endtask

  task automatic dm_access(input logic we, input logic [31:0] a, input logic [31:0] wd,
                           input logic [2:0] f3, input logic [31:0] exp_data, input string tag);
    applyStimulus(1'b0, 32'h0, 1'b1, we, a, wd, f3);
    #1;
    checkOutput({tag, "_gnt"}, {31'h0, dm_gnt_o}, 32'h1);
    step();
    idle();
    step();
    checkOutput({tag, "_rvalid"}, {31'h0, dm_rvalid_o}, 32'h1);
    checkOutput({tag, "_rdata"}, dm_rdata_o, exp_data);
    step();
  endtask

  task automatic run_hand();
    logic [31:0] exp_w [8];
    // Single fetch
    dm_access(1'b1, 32'h0100_0000, 32'h0050_0093, 3'b010, 32'h0, "preload");
    applyStimulus(1'b1, 32'h0100_0000, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    #1;
    checkOutput("fetch_gnt", {31'h0, if_gnt_o}, 32'h1);
    step();
    checkOutput("fetch_acc", {28'h0, mem_read_en_o, mem_funct3_o}, {28'h0, 1'b1, 3'b010});
    checkOutput("fetch_acc_addr", mem_addr_o, 32'h0100_0000);
    idle();
    step();
    checkOutput("fetch_rvalid", {31'h0, if_rvalid_o}, 32'h1);
    checkOutput("fetch_rdata", if_rdata_o, 32'h0050_0093);
    step();
    checkOutput("fetch_rvalid_pulse", {31'h0, if_rvalid_o}, 32'h0);

    // Store then load on consecutive cycles
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h0100_0100, 32'hDEAD_BEEF, 3'b010);
    #1;
    checkOutput("sl_st_gnt", {31'h0, dm_gnt_o}, 32'h1);
    step();
    checkOutput("sl_wr_en", {31'h0, mem_write_en_o}, 32'h1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0100_0101, 32'h0, 3'b100);
    #1;
    checkOutput("sl_ld_gnt", {31'h0, dm_gnt_o}, 32'h1);
    step();
    checkOutput("sl_ack", {dm_rvalid_o, dm_rdata_o[30:0]}, 32'h8000_0000);
    checkOutput("sl_rd_en", {31'h0, mem_read_en_o}, 32'h1);
    idle();
    step();
    checkOutput("sl_ld_rvalid", {31'h0, dm_rvalid_o}, 32'h1);
    checkOutput("sl_ld_rdata", dm_rdata_o, 32'h0000_00BE);
    step();

    // Simultaneous requests: data first, fetch on the next cycle
    applyStimulus(1'b1, 32'h0100_0000, 1'b1, 1'b0, 32'h0100_0100, 32'h0, 3'b010);
    #1;
    checkOutput("sim_gnt0", {30'h0, if_gnt_o, dm_gnt_o}, 32'h1);
    step();
    applyStimulus(1'b1, 32'h0100_0000, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    #1;
    checkOutput("sim_gnt1", {30'h0, if_gnt_o, dm_gnt_o}, 32'h2);
    step();
    idle();
    checkOutput("sim_resp0", {30'h0, if_rvalid_o, dm_rvalid_o}, 32'h1);
    checkOutput("sim_dm_rdata", dm_rdata_o, 32'hDEAD_BEEF);
    step();
    checkOutput("sim_resp1", {30'h0, if_rvalid_o, dm_rvalid_o}, 32'h2);
    checkOutput("sim_if_rdata", if_rdata_o, 32'h0050_0093);
    step();

    // Reset during the ACCESS cycle of a store
    dm_access(1'b1, 32'h0100_0200, 32'h1122_3344, 3'b010, 32'h0, "rst_pre");
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h0100_0200, 32'hCAFE_F00D, 3'b010);
    #1;
    checkOutput("rst_st_gnt", {31'h0, dm_gnt_o}, 32'h1);
    step();
    idle();
    checkOutput("rst_st_wr_en", {31'h0, mem_write_en_o}, 32'h1);
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("midrst");
    step();
    checkOutput("midrst_no_rvalid", {31'h0, dm_rvalid_o}, 32'h0);
    rst = 1'b1;
    dm_access(1'b0, 32'h0100_0200, 32'h0, 3'b010, 32'h1122_3344, "rst_post_ld");

    // Eight back-to-back fetches
    for (int k = 0; k < 8; k++) begin
      exp_w[k] = (k == 0) ? 32'h0050_0093 :
                 {init_byte(12'(4*k + 3)), init_byte(12'(4*k + 2)),
                  init_byte(12'(4*k + 1)), init_byte(12'(4*k))};
    end
    for (int c = 0; c < 11; c++) begin
      if (c >= 2 && c <= 9) begin
        checkOutput($sformatf("b2b%0d_rvalid", c), {31'h0, if_rvalid_o}, 32'h1);
        checkOutput($sformatf("b2b%0d_rdata", c), if_rdata_o, exp_w[c - 2]);
      end else begin
        checkOutput($sformatf("b2b%0d_rvalid", c), {31'h0, if_rvalid_o}, 32'h0);
      end
      checkOutput($sformatf("b2b%0d_busy", c), {31'h0, busy_o}, {31'h0, (c >= 1 && c <= 8)});
      if (c < 8) applyStimulus(1'b1, 32'h0100_0000 + 32'(4 * c), 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
      else idle();
      #1;
      if (c < 8) checkOutput($sformatf("b2b%0d_gnt", c), {31'h0, if_gnt_o}, 32'h1);
      step();
    end
  endtask

  initial begin
    rst = 1'b0;
    idle();
    do_reset();
    run_table();
    do_reset();
    run_random();
    do_reset();
    run_hand();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
